fetch_sequencer: RTL

Controls the program counter and instruction fetch for the pipelined core. It owns PCF and issues requests to a variable-latency instruction memory, with one request outstanding at a time. It applies branch/jump redirects from the Execute stage using the PCsrc encoding, and fills the IF/ID register. It honours hazard-unit stalls through a one-entry skid buffer and squashes wrong-path fetches.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_skid.sv | 75 +++++++
 rtl/fetch_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch sequencer:
//     - fetch_state_e : sequencer states (IDLE, FETCH, HOLD, DROP)
//     - PCSRC_*       : encodings of the Execute-stage redirect select
//     - NOP_INSTR     : canonical NOP (addi x0, x0, 0) used to flush IF/ID
//     - is_redirect() : true when a PCsrc value requests a control transfer
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding, about to issue one
        FETCH = 2'd1,   // request outstanding, response will be used
        HOLD  = 2'd2,   // response parked in the skid buffer, IF/ID stalled
        DROP  = 2'd3    // request outstanding, response will be discarded
    } fetch_state_e;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // 2'b11 is reserved and behaves like sequential fetch.
    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return (pcsrc == PCSRC_BRANCH) || (pcsrc == PCSRC_JALR);
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_skid.sv
// ----------------------------------------------------------------------------
// fetch_skid
//   One-entry holding buffer for an instruction word that returned from
//   instruction memory while decode was stalled. The entry carries the word
//   and the address it was fetched from.
//
//   Ports
//     clk      in   clock
//     rst      in   synchronous active-high reset (empties the buffer)
//     load_i   in   capture {instr_i, pc_i}, mark entry valid
//     pop_i    in   entry consumed, mark empty
//     clear_i  in   discard the entry (wrong-path flush); wins over load/pop
//     instr_i  in   instruction word to capture
//     pc_i     in   fetch address of instr_i
//     valid_o  out  entry holds a word
//     instr_o  out  buffered instruction word
//     pc_o     out  buffered fetch address
// ----------------------------------------------------------------------------
module fetch_skid #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc_q;

    always_comb begin
        // NOTE: the next-state value is defaulted before any condition so
        // every path assigns it and no latch is inferred.
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: flops are written with non-blocking assignments so every
    // register in the design samples its pre-edge inputs, independent of
    // block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload is only ever read while valid_q is set, so it has no
    // reset and stays a plain enable register.
    always_ff @(posedge clk) begin
        if (load_i && !clear_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule : fetch_skid

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the fetch PC (PCF), drives a single-outstanding-request instruction
//   memory port, applies Execute-stage redirects and fills the IF/ID register.
//   Decode stalls are absorbed by a one-entry skid buffer; responses to
//   wrong-path requests are drained and discarded.
//
//   Parameters
//     WIDTH     datapath / address width
//     RESET_PC  PCF value after reset
//
//   Ports
//     clk          in   clock
//     rst          in   synchronous active-high reset
//     PCsrc        in   redirect select: 00 none, 01 PCE+ImmExtE,
//                       10 {ALUResultE[W-1:1],0}, 11 none
//     PCE          in   PC of the instruction in Execute
//     ImmExtE      in   sign-extended immediate in Execute
//     ALUResultE   in   ALU result in Execute (JALR target)
//     StallD       in   hazard unit: hold IF/ID
//     imem_req     out  fetch request
//     imem_addr    out  fetch address, stable while imem_req=1
//     imem_rvalid  in   response valid, ends the outstanding request
//     imem_rdata   in   instruction word
//     PCF          out  next PC to be fetched
//     InstrD       out  IF/ID instruction
//     PCD          out  IF/ID PC
//     PCPlus4D     out  IF/ID PC+4
//     ValidD       out  IF/ID holds a real instruction
// ----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PCsrc,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] ImmExtE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic             StallD,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);
    localparam logic [WIDTH-1:0] NOP_W   = WIDTH'(NOP_INSTR);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pcf_q, pcf_d;
    logic [WIDTH-1:0] addr_q, addr_d;

    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
    logic             ifid_valid_q, ifid_valid_d;

    logic             skid_load;
    logic             skid_pop;
    logic             skid_clear;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_instr;
    logic [WIDTH-1:0] skid_pc;

    // ------------------------------------------------------------------
    // Redirect target mux (modulo 2^WIDTH; JALR only clears bit 0)
    // ------------------------------------------------------------------
    logic             redirect;
    logic [WIDTH-1:0] target;

    always_comb begin
        redirect = is_redirect(PCsrc);
        target   = pcf_q;
        case (PCsrc)
            PCSRC_BRANCH: target = PCE + ImmExtE;
            PCSRC_JALR:   target = {ALUResultE[WIDTH-1:1], 1'b0};
            default:      target = pcf_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    fetch_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .clear_i (skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (addr_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        addr_d       = addr_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        skid_load    = 1'b0;
        skid_pop     = 1'b0;
        skid_clear   = 1'b0;

        if (redirect) begin
            // Flush overrides any stall. PCD/PCPlus4D are left as they were;
            // ValidD=0 is what tells decode the slot is empty.
            ifid_instr_d = NOP_W;
            ifid_valid_d = 1'b0;
            skid_clear   = 1'b1;
            pcf_d        = target;
            if ((state_q == FETCH || state_q == DROP) && !imem_rvalid) begin
                // A request is still in flight on the old address: keep it
                // on the bus and wait to throw its response away.
                state_d = DROP;
            end else begin
                // Nothing in flight any more (including a DROP whose stale
                // response lands this very cycle): start on the new path.
                state_d = FETCH;
                addr_d  = target;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    addr_d  = pcf_q;
                end

                FETCH: begin
                    if (imem_rvalid) begin
                        if (StallD && ifid_valid_q) begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            // PC+4 is taken from the address actually fetched.
                            ifid_instr_d = imem_rdata;
                            ifid_pc_d    = addr_q;
                            ifid_pc4_d   = addr_q + PC_STEP;
                            ifid_valid_d = 1'b1;
                            pcf_d        = pcf_q + PC_STEP;
                            addr_d       = addr_q + PC_STEP;
                        end
                    end
                end

                HOLD: begin
                    if (!skid_valid) begin
                        // Defensive: never strand the sequencer without a word.
                        state_d = FETCH;
                        addr_d  = pcf_q;
                    end else if (!StallD) begin
                        ifid_instr_d = skid_instr;
                        ifid_pc_d    = skid_pc;
                        ifid_pc4_d   = skid_pc + PC_STEP;
                        ifid_valid_d = 1'b1;
                        skid_pop     = 1'b1;
                        pcf_d        = pcf_q + PC_STEP;
                        addr_d       = pcf_q + PC_STEP;
                        state_d      = FETCH;
                    end
                end

                DROP: begin
                    // The stale word is dropped; PCF already holds the
                    // latest redirect target.
                    if (imem_rvalid) begin
                        addr_d  = pcf_q;
                        state_d = FETCH;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pcf_q        <= RESET_PC;
            addr_q       <= RESET_PC;
            ifid_instr_q <= NOP_W;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            addr_q       <= addr_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req  = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr = addr_q;
    assign PCF       = pcf_q;
    assign InstrD    = ifid_instr_q;
    assign PCD       = ifid_pc_q;
    assign PCPlus4D  = ifid_pc4_q;
    assign ValidD    = ifid_valid_q;

endmodule : fetch_sequencer
